// File: rtl/johnson_phase_monitor.sv
// ---------------------------------------------------------------------------
// johnson_phase_monitor
//
// Watches the code coming out of a 4-bit Johnson (twisted-ring) counter and
// produces the following:
//   * the decoded phase, both as an index and as a one-hot vector
//   * a check that each new code is a legal successor of the previous one
//   * a lock indication
//   * a count of completed revolutions while locked
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   count_in      in   [3:0] Johnson code from the upstream counter
//   clear_err     in   synchronous clear of err_sticky (a set in the same
//                      cycle takes priority)
//   phase         out  [2:0] index of the last legal code
//   phase_onehot  out  [7:0] one-hot of phase, zero while the code is illegal
//   valid_code    out  last sampled code is legal
//   locked        out  lock FSM is in LOCKED
//   err_illegal   out  one-cycle pulse, illegal code sampled
//   err_skip      out  one-cycle pulse, legal code that is neither hold nor step
//   err_sticky    out  latched OR of both error pulses
//   rev_count     out  [REV_W-1:0] revolutions completed while locked
//   rev_tick      out  one-cycle pulse when rev_count increments
//
// Lock FSM
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   UNLOCKED  | no run of legal steps in progress
//   ACQUIRE   | counting consecutive steps (holds allowed) toward LOCK_COUNT
//   LOCKED    | sequence trusted; steps and holds keep it, any fault drops it
//
// All outputs are registered, so they reflect the code sampled on the most
// recent rising edge.
// ---------------------------------------------------------------------------
module johnson_phase_monitor #(
   parameter int LOCK_COUNT = 4,
   parameter int REV_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       count_in,
   input  logic             clear_err,
   output logic [2:0]       phase,
   output logic [7:0]       phase_onehot,
   output logic             valid_code,
   output logic             locked,
   output logic             err_illegal,
   output logic             err_skip,
   output logic             err_sticky,
   output logic [REV_W-1:0] rev_count,
   output logic             rev_tick
);

   typedef enum logic [1:0] {
      S_UNLOCKED = 2'd0,
      S_ACQUIRE  = 2'd1,
      S_LOCKED   = 2'd2
   } state_t;

   // Returns {legal, index}. Illegal codes return index 0, which is never
   // used because the legal bit gates every consumer.
   function automatic logic [3:0] decode(input logic [3:0] code);
      logic [3:0] r;
      case (code)
         4'b0000: r = 4'b1_000;
         4'b0001: r = 4'b1_001;
         4'b0011: r = 4'b1_010;
         4'b0111: r = 4'b1_011;
         4'b1111: r = 4'b1_100;
         4'b1110: r = 4'b1_101;
         4'b1100: r = 4'b1_110;
         4'b1000: r = 4'b1_111;
         default: r = 4'b0_000;
      endcase
      return r;
   endfunction

   localparam logic [4:0] LOCK_TARGET = 5'(LOCK_COUNT);

   state_t     state;
   state_t     state_next;
   logic [3:0] prev_code;
   logic       have_prev;
   logic [3:0] streak;
   logic [3:0] streak_next;

   logic [3:0] dec;
   logic       code_legal;
   logic [2:0] code_idx;
   logic [3:0] succ_code;
   logic       cls_hold;
   logic       cls_step;
   logic       cls_skip;
   logic       cls_illegal;
   logic       fault;
   logic [4:0] streak_inc;
   logic       rev_hit;

   assign dec        = decode(count_in);
   assign code_legal = dec[3];
   assign code_idx   = dec[2:0];

   // The legal successor of any code is a left shift that feeds in the
   // inverted MSB.
   assign succ_code  = {prev_code[2:0], ~prev_code[3]};

   // The first sample after reset has no predecessor. It is checked only
   // for legality, and it never raises an error.
   assign cls_illegal = have_prev & ~code_legal;
   assign cls_hold    = have_prev & code_legal & (count_in == prev_code);
   assign cls_step    = have_prev & code_legal & (count_in == succ_code);
   assign cls_skip    = have_prev & code_legal & ~cls_hold & ~cls_step;
   assign fault       = cls_illegal | cls_skip;

   assign streak_inc  = {1'b0, streak} + 5'd1;

   // A revolution is counted only when the FSM was already LOCKED before
   // this edge.
   assign rev_hit     = cls_step & (prev_code == 4'b1000) & (state == S_LOCKED);

   always_comb begin
      state_next  = state;
      streak_next = streak;
      case (state)
         S_UNLOCKED: begin
            if (cls_step) begin
               streak_next = 4'd1;
               state_next  = (LOCK_TARGET == 5'd1) ? S_LOCKED : S_ACQUIRE;
            end
         end
         S_ACQUIRE: begin
            if (fault) begin
               streak_next = 4'd0;
               state_next  = S_UNLOCKED;
            end else if (cls_step) begin
               streak_next = streak_inc[3:0];
               if (streak_inc == LOCK_TARGET) begin
                  state_next = S_LOCKED;
               end
            end
         end
         S_LOCKED: begin
            if (fault) begin
               streak_next = 4'd0;
               state_next  = S_UNLOCKED;
            end
         end
         default: begin
            streak_next = 4'd0;
            state_next  = S_UNLOCKED;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_UNLOCKED;
         streak    <= 4'd0;
         prev_code <= 4'b0000;
         have_prev <= 1'b0;
      end else begin
         state     <= state_next;
         streak    <= streak_next;
         // Illegal codes are loaded as well. Leaving an illegal code
         // therefore always reads as a skip.
         prev_code <= count_in;
         have_prev <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase        <= 3'd0;
         phase_onehot <= 8'd0;
         valid_code   <= 1'b0;
      end else begin
         valid_code <= code_legal;
         if (code_legal) begin
            phase        <= code_idx;
            phase_onehot <= 8'b0000_0001 << code_idx;
         end else begin
            phase_onehot <= 8'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_illegal <= 1'b0;
         err_skip    <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         err_illegal <= cls_illegal;
         err_skip    <= cls_skip;
         err_sticky  <= (err_sticky & ~clear_err) | cls_illegal | cls_skip;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rev_count <= '0;
         rev_tick  <= 1'b0;
      end else begin
         rev_tick <= rev_hit;
         if (rev_hit) begin
            rev_count <= rev_count + REV_W'(1);
         end
      end
   end

   assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_johnson_phase_monitor.sv
module tb_johnson_phase_monitor;

   localparam int LOCK_COUNT = 4;
   localparam int REV_W      = 8;

   logic             clk;
   logic             reset;
   logic [3:0]       count_in;
   logic             clear_err;
   logic [2:0]       phase;
   logic [7:0]       phase_onehot;
   logic             valid_code;
   logic             locked;
   logic             err_illegal;
   logic             err_skip;
   logic             err_sticky;
   logic [REV_W-1:0] rev_count;
   logic             rev_tick;

   johnson_phase_monitor #(.LOCK_COUNT(LOCK_COUNT), .REV_W(REV_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .count_in     (count_in),
      .clear_err    (clear_err),
      .phase        (phase),
      .phase_onehot (phase_onehot),
      .valid_code   (valid_code),
      .locked       (locked),
      .err_illegal  (err_illegal),
      .err_skip     (err_skip),
      .err_sticky   (err_sticky),
      .rev_count    (rev_count),
      .rev_tick     (rev_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // The legal ring in phase order. The model moves around it by index.
   logic [3:0] ring [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

   // Reference model state.
   bit       m_have;
   int       m_prev_idx;   // -1 when the previous code was illegal
   logic [3:0] m_prev;
   int       m_run;
   bit       m_locked;
   int       m_phase;
   int       m_onehot;
   bit       m_valid;
   bit       m_ei;
   bit       m_es;
   bit       m_sticky;
   int       m_rev;
   bit       m_tick;

   logic [3:0] cur;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [3:0] c);
      for (int i = 0; i < 8; i++) if (ring[i] == c) return i;
      return -1;
   endfunction

   function automatic void m_reset();
      m_have = 0; m_prev_idx = 0; m_prev = 4'b0000; m_run = 0; m_locked = 0;
      m_phase = 0; m_onehot = 0; m_valid = 0; m_ei = 0; m_es = 0;
      m_sticky = 0; m_rev = 0; m_tick = 0;
   endfunction

   function automatic void m_edge(input logic [3:0] c, input bit clr);
      int  idx;
      bit  step, hold, skip, ill;
      idx  = idx_of(c);
      ill  = m_have && idx < 0;
      hold = m_have && idx >= 0 && c == m_prev;
      step = m_have && idx >= 0 && m_prev_idx >= 0 && idx == (m_prev_idx + 1) % 8;
      skip = m_have && idx >= 0 && !hold && !step;

      m_tick = step && m_locked && m_prev_idx == 7;
      if (m_tick) m_rev = (m_rev + 1) % (1 << REV_W);

      if (ill || skip) begin
         m_locked = 0;
         m_run    = 0;
      end else if (step && !m_locked) begin
         m_run++;
         if (m_run >= LOCK_COUNT) m_locked = 1;
      end

      m_ei = ill;
      m_es = skip;
      m_sticky = (m_sticky && !clr) || ill || skip;

      m_valid = idx >= 0;
      if (idx >= 0) begin
         m_phase  = idx;
         m_onehot = 1 << idx;
      end else begin
         m_onehot = 0;
      end

      m_prev     = c;
      m_prev_idx = idx;
      m_have     = 1;
   endfunction

   task automatic compare_all();
      check("phase",        32'(phase),        32'(m_phase));
      check("phase_onehot", 32'(phase_onehot), 32'(m_onehot));
      check("valid_code",   32'(valid_code),   32'(m_valid));
      check("locked",       32'(locked),       32'(m_locked));
      check("err_illegal",  32'(err_illegal),  32'(m_ei));
      check("err_skip",     32'(err_skip),     32'(m_es));
      check("err_sticky",   32'(err_sticky),   32'(m_sticky));
      check("rev_count",    32'(rev_count),    32'(m_rev));
      check("rev_tick",     32'(rev_tick),     32'(m_tick));
   endtask

   // Inputs change 1 ns after a rising edge; outputs are sampled there too.
   task automatic tick(input logic [3:0] c, input bit clr);
      count_in  = c;
      clear_err = clr;
      cur       = c;
      @(posedge clk);
      m_edge(c, clr);
      #1;
      compare_all();
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) tick(ring[(idx_of(cur) + 1) % 8], 1'b0);
   endtask

   // Reset asserted between edges, checked before any clock edge arrives.
   task automatic async_reset();
      #3;
      reset = 1'b1;
      #1;
      m_reset();
      check("rst_rev_count", 32'(rev_count), 32'd0);
      check("rst_locked",    32'(locked),    32'd0);
      compare_all();
      #2;
      reset = 1'b0;
   endtask

   task automatic acquire_from_zero();
      tick(4'b0000, 1'b0);
      step_n(4);
   endtask

   initial begin
      reset     = 1'b1;
      count_in  = 4'b0101;
      clear_err = 1'b0;
      cur       = 4'b0101;
      m_reset();
      #15;
      check("reset_onehot", 32'(phase_onehot), 32'd0);
      check("reset_sticky", 32'(err_sticky),   32'd0);
      compare_all();
      @(negedge clk);
      reset = 1'b0;

      // First sample is illegal but has no predecessor: no error.
      tick(4'b0101, 1'b0);
      check("first_valid",   32'(valid_code),  32'd0);
      check("first_illegal", 32'(err_illegal), 32'd0);

      // Acquire and revolution.
      async_reset();
      acquire_from_zero();
      check("acq_locked", 32'(locked),       32'd1);
      check("acq_phase",  32'(phase),        32'd4);
      check("acq_onehot", 32'(phase_onehot), 32'h10);
      step_n(4);
      check("rev_tick_1",  32'(rev_tick),  32'd1);
      check("rev_count_1", 32'(rev_count), 32'd1);
      step_n(1);
      check("rev_tick_0",  32'(rev_tick),  32'd0);
      step_n(299);
      check("rev_count_wrap", 32'(rev_count), 32'h26);

      // Holds during acquisition.
      async_reset();
      tick(4'b0000, 1'b0);
      tick(4'b0001, 1'b0);
      tick(4'b0001, 1'b0);
      tick(4'b0001, 1'b0);
      tick(4'b0011, 1'b0);
      tick(4'b0111, 1'b0);
      tick(4'b1111, 1'b0);
      check("hold_locked", 32'(locked),     32'd1);
      check("hold_sticky", 32'(err_sticky), 32'd0);

      // Illegal code while locked at phase 3.
      step_n(7);
      check("pre_ill_phase", 32'(phase), 32'd3);
      tick(4'b0101, 1'b0);
      check("ill_pulse",  32'(err_illegal),  32'd1);
      check("ill_locked", 32'(locked),       32'd0);
      check("ill_onehot", 32'(phase_onehot), 32'd0);
      check("ill_phase",  32'(phase),        32'd3);
      check("ill_sticky", 32'(err_sticky),   32'd1);

      // Skip while locked, then sticky clear behaviour.
      async_reset();
      acquire_from_zero();
      step_n(5);
      check("pre_skip_locked", 32'(locked), 32'd1);
      tick(4'b0111, 1'b0);
      check("skip_pulse",  32'(err_skip), 32'd1);
      check("skip_locked", 32'(locked),   32'd0);
      tick(4'b0111, 1'b1);
      check("clear_sticky", 32'(err_sticky), 32'd0);
      tick(4'b0101, 1'b1);
      check("set_wins", 32'(err_sticky), 32'd1);

      // Mid-revolution reset.
      acquire_from_zero();
      step_n(6);
      async_reset();

      // Randomised mix of steps, holds, arbitrary codes, clears and resets.
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [3:0] c;
         r = $urandom_range(99);
         if (r < 65)
            c = (idx_of(cur) >= 0) ? ring[(idx_of(cur) + 1) % 8] : ring[$urandom_range(7)];
         else if (r < 85)
            c = cur;
         else
            c = 4'($urandom_range(15));
         tick(c, $urandom_range(9) == 0);
         if ($urandom_range(199) == 0) async_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
